// File: rtl/cpu_step_ctrl_if.sv
// Bus between the CPU step controller and its environment: raw operator
// inputs, CPU halt status, and the enable/debug outputs.
interface cpu_step_ctrl_if;
  logic        KEY_STEP;  // raw push-button, 0 = pressed
  logic        MODE_RUN;  // raw slide switch, 1 = run
  logic [2:0]  SPEED;     // run-rate select
  logic        HALT;      // CPU reports halted
  logic        CPU_EN;    // clock enable to CPU
  logic        RUNNING;   // FSM is in RUN
  logic        KEY_DB;    // debounced key level
  logic [15:0] STEP_CNT;  // issued enables, mod 2^16

  // Environment side: drives operator inputs and halt, observes outputs.
  modport master (
    output KEY_STEP, MODE_RUN, SPEED, HALT,
    input  CPU_EN, RUNNING, KEY_DB, STEP_CNT
  );

  // Controller side.
  modport slave (
    input  KEY_STEP, MODE_RUN, SPEED, HALT,
    output CPU_EN, RUNNING, KEY_DB, STEP_CNT
  );
endinterface

// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable generator: debounced single-step button and run switch,
// run-mode rate divider, halt gating and an enable counter for debug display.
module cpu_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic          CLK1_50,
  input  logic          RST,
  cpu_step_ctrl_if.slave bus
);

  localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Bit 0 = key (idles released/high), bit 1 = mode (idles in step mode/low).
  localparam logic [1:0]      RST_LVL  = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_RUN,
    S_HALTED
  } state_t;

  logic [1:0]  w_raw;
  logic [1:0]  w_db;
  logic        w_key_db;
  logic        w_mode_db;
  logic        w_cpu_en;
  logic [4:0]  w_shamt;
  logic [20:0] w_div_last;
  logic        w_speed_chg;
  logic [20:0] w_div_eff;
  logic        w_div_hit;

  state_t      r_state;
  logic        r_en;
  logic        r_running;
  logic        r_key_prev;
  logic        r_step_req;
  logic [20:0] r_div;
  logic [2:0]  r_speed_prev;
  logic [15:0] r_step_cnt;

  assign w_raw = {bus.MODE_RUN, bus.KEY_STEP};

  // One synchronizer + debouncer per asynchronous operator input.
  for (genvar gi = 0; gi < 2; gi++) begin : g_db
    logic             r_s1;
    logic             r_s2;
    logic             r_lvl;
    logic [CNT_W-1:0] r_cnt;

    // Two-flop synchronizer, then accept a new level only after it has been
    // seen on DEBOUNCE_CYCLES consecutive samples; any agreement with the
    // current level restarts the count.
    always_ff @(posedge CLK1_50) begin
      if (RST) begin
        r_s1  <= RST_LVL[gi];
        r_s2  <= RST_LVL[gi];
        r_lvl <= RST_LVL[gi];
        r_cnt <= '0;
      end else begin
        r_s1 <= w_raw[gi];
        r_s2 <= r_s1;
        if (r_s2 == r_lvl) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_lvl <= r_s2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_db[gi] = r_lvl;
  end

  assign w_key_db  = w_db[0];
  assign w_mode_db = w_db[1];

  // Registered press detect: one-cycle request on a debounced 1->0 edge.
  always_ff @(posedge CLK1_50) begin
    if (RST) begin
      r_key_prev <= 1'b1;
      r_step_req <= 1'b0;
    end else begin
      r_key_prev <= w_key_db;
      r_step_req <= r_key_prev & ~w_key_db;
    end
  end

  // Period is 2^(3*SPEED); the terminal count P-1 is a mask of 3*SPEED ones.
  // Shifting by 21 at SPEED=7 empties the constant, giving the full 21-bit mask.
  assign w_shamt     = {2'b00, bus.SPEED} * 5'd3;
  assign w_div_last  = ~(21'h1FFFFF << w_shamt);
  assign w_speed_chg = (bus.SPEED != r_speed_prev);
  // A rate change restarts counting from zero in the same cycle, so the first
  // pulse at the new rate lands P cycles after the change.
  assign w_div_eff   = (r_state != S_RUN || w_speed_chg) ? 21'd0 : r_div;
  assign w_div_hit   = (w_div_eff == w_div_last);

  // Rate divider: held at zero outside RUN, wraps at P-1 while running.
  always_ff @(posedge CLK1_50) begin
    if (RST) begin
      r_div        <= '0;
      r_speed_prev <= '0;
    end else begin
      r_speed_prev <= bus.SPEED;
      if (r_state != S_RUN) begin
        r_div <= '0;
      end else if (w_div_hit) begin
        r_div <= '0;
      end else begin
        r_div <= w_div_eff + 21'd1;
      end
    end
  end

  // Control FSM; RUNNING and the raw enable are registered alongside the state
  // so they are valid in the same cycle as the state they describe.
  always_ff @(posedge CLK1_50) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_en      <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_en      <= 1'b0;
      r_running <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.HALT) begin
            r_state <= S_HALTED;
          end else if (w_mode_db) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end else if (r_step_req) begin
            r_state <= S_STEP;
            r_en    <= 1'b1;
          end
        end
        S_STEP: begin
          r_state <= S_IDLE;
        end
        S_RUN: begin
          if (bus.HALT) begin
            r_state <= S_HALTED;
          end else if (!w_mode_db) begin
            r_state <= S_IDLE;
          end else begin
            r_running <= 1'b1;
            r_en      <= w_div_hit;
          end
        end
        S_HALTED: begin
          if (!bus.HALT) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Halt masks the enable combinationally so nothing leaks the cycle it rises.
  assign w_cpu_en = r_en & ~bus.HALT;

  // Count every cycle in which the CPU actually advanced.
  always_ff @(posedge CLK1_50) begin
    if (RST) begin
      r_step_cnt <= '0;
    end else if (w_cpu_en) begin
      r_step_cnt <= r_step_cnt + 16'd1;
    end
  end

  assign bus.CPU_EN   = w_cpu_en;
  assign bus.RUNNING  = r_running;
  assign bus.KEY_DB   = w_key_db;
  assign bus.STEP_CNT = r_step_cnt;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Scoreboard bench for cpu_step_ctrl with DEBOUNCE_CYCLES=4. Stimulus pushes
// the edge number and STEP_CNT expected for each CPU_EN pulse; a negedge
// monitor pops and compares whenever CPU_EN is seen high.
module tb_cpu_step_ctrl;

  logic clk = 1'b0;
  logic rst;

  cpu_step_ctrl_if bus_if ();

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLK1_50(clk),
    .RST    (rst),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge e, cyc == e.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_cnt  = 0;
  bit   sb_track = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) begin
      n_pass++;
      $display("ok   %-16s cyc=%0d value=%0h", name, cyc, act);
    end else begin
      $display("FAIL %-16s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expect a pulse in the cycle after edge 'at'; STEP_CNT then still shows
  // the count before this pulse.
  task automatic push_pulse(input int at);
    sb_q.push_back('{at: at, cnt: 16'(exp_cnt)});
    exp_cnt++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  // Monitor: retire overdue expectations, then match any observed pulse.
  always @(negedge clk) begin
    if (rst !== 1'b1 && sb_track) begin
      while (sb_q.size() > 0 && sb_q[0].at < cyc) begin
        n_checks++;
        $display("FAIL pulse_missing    expected_at=%0d now=%0d", sb_q[0].at, cyc);
        void'(sb_q.pop_front());
      end
      if (bus_if.CPU_EN === 1'b1) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          $display("FAIL pulse_unexpected cyc=%0d step_cnt=%0h", cyc, bus_if.STEP_CNT);
        end else begin
          mon_e = sb_q.pop_front();
          if (mon_e.at == cyc && bus_if.STEP_CNT === mon_e.cnt) begin
            n_pass++;
            $display("ok   pulse            cyc=%0d step_cnt=%0h", cyc, bus_if.STEP_CNT);
          end else begin
            $display("FAIL pulse            actual cyc=%0d cnt=%0h required cyc=%0d cnt=%0h",
                     cyc, bus_if.STEP_CNT, mon_e.at, mon_e.cnt);
          end
        end
      end
    end
  end

  initial begin
    int n;
    int m;
    int c;
    int h;
    int s0;
    bit seen_low;

    // Reset with key pressed and switch in run: outputs must hold reset values.
    rst             = 1'b1;
    bus_if.KEY_STEP = 1'b0;
    bus_if.MODE_RUN = 1'b1;
    bus_if.SPEED    = 3'd7;
    bus_if.HALT     = 1'b0;
    tick(1);
    check("rst_cpu_en", bus_if.CPU_EN, 0);
    check("rst_running", bus_if.RUNNING, 0);
    check("rst_key_db", bus_if.KEY_DB, 1);
    check("rst_step_cnt", bus_if.STEP_CNT, 0);
    tick(2);
    check("rst3_running", bus_if.RUNNING, 0);
    check("rst3_key_db", bus_if.KEY_DB, 1);
    rst = 1'b0;
    tick(6);
    check("post_rst_key_db", bus_if.KEY_DB, 0);
    check("post_rst_run6", bus_if.RUNNING, 0);
    tick(1);
    check("post_rst_run7", bus_if.RUNNING, 1);

    // Single step: one pulse 7 edges after the key is first sampled low.
    bus_if.KEY_STEP = 1'b1;
    bus_if.MODE_RUN = 1'b0;
    bus_if.SPEED    = 3'd0;
    do_reset();
    bus_if.KEY_STEP = 1'b0;
    n = cyc + 1;
    push_pulse(n + 7);
    tick(5);
    check("step_db_hold", bus_if.KEY_DB, 1);
    tick(1);
    check("step_db_fall", bus_if.KEY_DB, 0);
    tick(15);
    bus_if.KEY_STEP = 1'b1;
    tick(10);
    check("step_cnt_1", bus_if.STEP_CNT, 1);
    bus_if.KEY_STEP = 1'b0;
    n = cyc + 1;
    push_pulse(n + 7);
    tick(20);
    bus_if.KEY_STEP = 1'b1;
    tick(10);
    check("step_cnt_2", bus_if.STEP_CNT, 2);
    check("step_drained", sb_q.size(), 0);

    // Bounce: pulses shorter than the debounce window are never accepted.
    do_reset();
    seen_low = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus_if.KEY_STEP = (i % 2 == 0) ? 1'b0 : 1'b1;
      for (int j = 0; j < 2; j++) begin
        tick(1);
        if (bus_if.KEY_DB !== 1'b1) seen_low = 1'b1;
      end
    end
    bus_if.KEY_STEP = 1'b1;
    tick(10);
    check("bounce_db_low", 32'(seen_low), 0);
    check("bounce_step_cnt", bus_if.STEP_CNT, 0);

    // Run at SPEED=1 (P=8), then SPEED=0 (continuous).
    bus_if.SPEED = 3'd1;
    do_reset();
    bus_if.MODE_RUN = 1'b1;
    n = cyc + 1;
    tick(6);
    check("run_rise_early", bus_if.RUNNING, 0);
    tick(1);
    check("run_rise", bus_if.RUNNING, 1);
    m = cyc;
    push_pulse(m + 8);
    push_pulse(m + 16);
    push_pulse(m + 24);
    tick(26);
    c = cyc;
    bus_if.SPEED = 3'd0;
    s0 = exp_cnt;
    for (int i = 1; i <= 101; i++) push_pulse(c + i);
    tick(101);
    check("run_cnt_plus100", bus_if.STEP_CNT, 32'(s0 + 100));

    // Halt masks the enable immediately and parks the FSM.
    tick(1);
    bus_if.HALT = 1'b1;
    #1;
    check("halt_mask", bus_if.CPU_EN, 0);
    tick(1);
    check("halt_running", bus_if.RUNNING, 0);
    check("halt_cnt", bus_if.STEP_CNT, 32'(exp_cnt));
    bus_if.KEY_STEP = 1'b0;
    tick(12);
    bus_if.KEY_STEP = 1'b1;
    tick(12);
    check("halt_press_cnt", bus_if.STEP_CNT, 32'(exp_cnt));
    check("halt_drained", sb_q.size(), 0);
    bus_if.HALT = 1'b0;
    h = cyc;
    tick(1);
    check("unhalt_idle", bus_if.RUNNING, 0);
    tick(1);
    check("unhalt_run", bus_if.RUNNING, 1);
    for (int i = 3; i <= 11; i++) push_pulse(h + i);
    tick(10);
    check("resume_drained", sb_q.size(), 0);
    check("resume_cnt", bus_if.STEP_CNT, 32'(exp_cnt));

    // Wrap: 65536 continuous enables bring STEP_CNT back to zero.
    sb_track = 1'b0;
    bus_if.KEY_STEP = 1'b1;
    bus_if.MODE_RUN = 1'b1;
    bus_if.SPEED    = 3'd0;
    do_reset();
    tick(65543);
    check("wrap_ffff", bus_if.STEP_CNT, 32'h0000FFFF);
    tick(1);
    check("wrap_0000", bus_if.STEP_CNT, 0);

    // Reset mid-run stops enables at the next edge.
    rst = 1'b1;
    tick(1);
    check("midrst_cpu_en", bus_if.CPU_EN, 0);
    check("midrst_running", bus_if.RUNNING, 0);
    check("midrst_cnt", bus_if.STEP_CNT, 0);
    rst = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
